// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipeline: word/register typedefs, writeback
// source encoding and the memory-stage state encoding.
package cpu_types_pkg;

    localparam int WORD_W   = 32;
    localparam int REGIDX_W = 5;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [REGIDX_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_NPC = 2'b01,
        SRC_LUI = 2'b10,
        SRC_MEM = 2'b11
    } regsrc_t;

    typedef logic [0:0] memstate_t;
    localparam memstate_t IDLE   = 1'b0;
    localparam memstate_t ACCESS = 1'b1;

    // A request with both read and write set is a store.
    function automatic logic is_load(input logic rd, input logic wr);
        return rd & ~wr;
    endfunction

endpackage

// File: rtl/link_reg.sv
// LL/SC link register: remembers the address of the last completed LL.
// Only part of the build when MEM_STAGE_LLSC_EN is defined.
`ifdef MEM_STAGE_LLSC_EN
module link_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] set_addr_i,
    input  logic [DATA_W-1:0] chk_addr_i,
    output logic              sc_pass_o
);

    logic              link_valid_q, link_valid_d;
    logic [DATA_W-1:0] link_addr_q, link_addr_d;

    // Next link state; a clear in the same cycle as a set wins.
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (clr_i) begin
            link_valid_d = 1'b0;
        end else if (set_i) begin
            link_valid_d = 1'b1;
            link_addr_d  = set_addr_i;
        end else begin
            link_valid_d = link_valid_q;
        end
    end

    // Link register storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign sc_pass_o = link_valid_q & (chk_addr_i == link_addr_q);

endmodule
`endif

// File: rtl/mem_stage.sv
// MIPS pipeline memory stage: latches EX results and runs the dmem handshake.
// Define MEM_STAGE_LLSC_EN to add LL/SC link support (ex_ll, ex_sc, link_clr).
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_regWr,
    input  logic [REG_AW-1:0] ex_regDst,
    input  logic [1:0]        ex_regSrc,
    input  logic              ex_memRd,
    input  logic              ex_memWr,
    input  logic [DATA_W-1:0] ex_ALUOut,
    input  logic [DATA_W-1:0] ex_npc,
    input  logic [DATA_W-1:0] ex_lui,
    input  logic [DATA_W-1:0] ex_store,
`ifdef MEM_STAGE_LLSC_EN
    input  logic              ex_ll,
    input  logic              ex_sc,
    input  logic              link_clr,
`endif
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [DATA_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              mem_busy,
    output logic              valid_me,
    output logic              regWr_me,
    output logic [REG_AW-1:0] regDst_me,
    output logic [1:0]        regSrc_me,
    output logic [DATA_W-1:0] ALUOut_me,
    output logic [DATA_W-1:0] npc_me,
    output logic [DATA_W-1:0] lui_me,
    output logic [DATA_W-1:0] dmemload_me
);

    memstate_t         state_q, state_d;
    logic              valid_q, valid_d;
    logic              regwr_q, regwr_d;
    logic              memrd_q, memrd_d;
    logic              memwr_q, memwr_d;
    logic [REG_AW-1:0] regdst_q, regdst_d;
    regsrc_t           regsrc_q, regsrc_d;
    logic [DATA_W-1:0] aluout_q, aluout_d;
    logic [DATA_W-1:0] npc_q, npc_d;
    logic [DATA_W-1:0] lui_q, lui_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic              busy_s;
    logic              live_s;
    logic              valid_s;

    assign busy_s = (state_q == ACCESS);
    assign live_s = ex_valid & ~flush;

`ifdef MEM_STAGE_LLSC_EN
    logic ll_q, ll_d;
    logic sc_q, sc_d;
    logic sc_pass_s;
    logic link_set_s;
    logic link_clr_s;
    logic capture_s;

    assign capture_s  = (state_q == IDLE) & live_s;
    assign link_set_s = busy_s & dhit & ll_q;
    // Any SC or any plain store that hits the linked address breaks the link.
    assign link_clr_s = link_clr | (capture_s & ex_sc)
                      | (capture_s & ex_memWr & sc_pass_s);

    link_reg #(
        .DATA_W (DATA_W)
    ) u_link_reg (
        .clk_i      (CLK),
        .rst_ni     (nRST),
        .set_i      (link_set_s),
        .clr_i      (link_clr_s),
        .set_addr_i (aluout_q),
        .chk_addr_i (ex_ALUOut),
        .sc_pass_o  (sc_pass_s)
    );
`endif

    // Capture from EX while idle; complete the outstanding access on dhit.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        regwr_d  = regwr_q;
        memrd_d  = memrd_q;
        memwr_d  = memwr_q;
        regdst_d = regdst_q;
        regsrc_d = regsrc_q;
        aluout_d = aluout_q;
        npc_d    = npc_q;
        lui_d    = lui_q;
        store_d  = store_q;
        load_d   = load_q;
`ifdef MEM_STAGE_LLSC_EN
        ll_d     = ll_q;
        sc_d     = sc_q;
`endif
        case (state_q)
            IDLE: begin
                valid_d  = live_s;
                regwr_d  = ex_regWr & live_s;
                regdst_d = ex_regDst;
                regsrc_d = regsrc_t'(ex_regSrc);
                aluout_d = ex_ALUOut;
                npc_d    = ex_npc;
                lui_d    = ex_lui;
                store_d  = ex_store;
`ifdef MEM_STAGE_LLSC_EN
                ll_d     = ex_ll & live_s;
                sc_d     = ex_sc & live_s;
                memrd_d  = (ex_memRd | ex_ll) & ~ex_sc & live_s;
                memwr_d  = live_s & (ex_sc ? sc_pass_s : ex_memWr);
                // A failing SC never reaches memory; it reports 0 right away.
                if (live_s & ex_sc & ~sc_pass_s) begin
                    load_d = '0;
                end else begin
                    load_d = load_q;
                end
`else
                memrd_d  = ex_memRd & live_s;
                memwr_d  = ex_memWr & live_s;
`endif
                if (memrd_d | memwr_d) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (dhit) begin
                    state_d = IDLE;
`ifdef MEM_STAGE_LLSC_EN
                    if (sc_q) begin
                        load_d = {{(DATA_W-1){1'b0}}, 1'b1};
                    end else if (is_load(memrd_q, memwr_q)) begin
                        load_d = dmemload;
                    end else begin
                        load_d = load_q;
                    end
`else
                    if (is_load(memrd_q, memwr_q)) begin
                        load_d = dmemload;
                    end else begin
                        load_d = load_q;
                    end
`endif
                end else begin
                    state_d = ACCESS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pipeline register and FSM state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            regwr_q  <= 1'b0;
            memrd_q  <= 1'b0;
            memwr_q  <= 1'b0;
            regdst_q <= '0;
            regsrc_q <= SRC_ALU;
            aluout_q <= '0;
            npc_q    <= '0;
            lui_q    <= '0;
            store_q  <= '0;
            load_q   <= '0;
`ifdef MEM_STAGE_LLSC_EN
            ll_q     <= 1'b0;
            sc_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            regwr_q  <= regwr_d;
            memrd_q  <= memrd_d;
            memwr_q  <= memwr_d;
            regdst_q <= regdst_d;
            regsrc_q <= regsrc_d;
            aluout_q <= aluout_d;
            npc_q    <= npc_d;
            lui_q    <= lui_d;
            store_q  <= store_d;
            load_q   <= load_d;
`ifdef MEM_STAGE_LLSC_EN
            ll_q     <= ll_d;
            sc_q     <= sc_d;
`endif
        end
    end

    // regWr is gated by valid so forwarding never sees an unfinished load.
    assign valid_s     = ~busy_s & valid_q;
    assign valid_me    = valid_s;
    assign regWr_me    = regwr_q & valid_s;
    assign mem_busy    = busy_s;
    assign dmemREN     = busy_s & is_load(memrd_q, memwr_q);
    assign dmemWEN     = busy_s & memwr_q;
    assign dmemaddr    = aluout_q;
    assign dmemstore   = store_q;
    assign regDst_me   = regdst_q;
    assign regSrc_me   = regsrc_q;
    assign ALUOut_me   = aluout_q;
    assign npc_me      = npc_q;
    assign lui_me      = lui_q;
    assign dmemload_me = load_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_mem_stage;

    logic        CLK, nRST, flush, ex_valid, ex_regWr, ex_memRd, ex_memWr;
    logic [4:0]  ex_regDst;
    logic [1:0]  ex_regSrc;
    logic [31:0] ex_ALUOut, ex_npc, ex_lui, ex_store;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN, mem_busy, valid_me, regWr_me;
    logic [31:0] dmemaddr, dmemstore, ALUOut_me, npc_me, lui_me, dmemload_me;
    logic [4:0]  regDst_me;
    logic [1:0]  regSrc_me;
`ifdef MEM_STAGE_LLSC_EN
    logic        ex_ll, ex_sc, link_clr;
`endif

    int n_checks;
    int n_fail;
    bit cmp_en;

    mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .ex_valid(ex_valid),
        .ex_regWr(ex_regWr), .ex_regDst(ex_regDst), .ex_regSrc(ex_regSrc),
        .ex_memRd(ex_memRd), .ex_memWr(ex_memWr), .ex_ALUOut(ex_ALUOut),
        .ex_npc(ex_npc), .ex_lui(ex_lui), .ex_store(ex_store),
`ifdef MEM_STAGE_LLSC_EN
        .ex_ll(ex_ll), .ex_sc(ex_sc), .link_clr(link_clr),
`endif
        .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_busy(mem_busy),
        .valid_me(valid_me), .regWr_me(regWr_me), .regDst_me(regDst_me),
        .regSrc_me(regSrc_me), .ALUOut_me(ALUOut_me), .npc_me(npc_me),
        .lui_me(lui_me), .dmemload_me(dmemload_me)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction view of the stage: what is held and whether it still waits on memory.
    typedef struct packed {
        logic        busy;
        logic        valid;
        logic        regwr;
        logic        rd;
        logic        wr;
        logic [4:0]  dst;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] npc;
        logic [31:0] lui;
        logic [31:0] st;
        logic [31:0] ld;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(input mdl_t cur);
        mdl_t nx;
        bit   live;
        nx = cur;
        if (!cur.busy) begin
            live     = ex_valid && !flush;
            nx.valid = live;
            nx.regwr = ex_regWr && live;
            nx.rd    = ex_memRd && live;
            nx.wr    = ex_memWr && live;
            nx.dst   = ex_regDst;
            nx.src   = ex_regSrc;
            nx.alu   = ex_ALUOut;
            nx.npc   = ex_npc;
            nx.lui   = ex_lui;
            nx.st    = ex_store;
            nx.busy  = nx.rd || nx.wr;
        end else if (dhit) begin
            if (cur.rd && !cur.wr) nx.ld = dmemload;
            nx.busy = 1'b0;
        end
        return nx;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) m <= '0;
        else       m <= step(m);
    end

    always @(negedge CLK) begin
        if (nRST === 1'b1 && cmp_en) begin
            chk("m_ren",      dmemREN,     m.busy && m.rd && !m.wr);
            chk("m_wen",      dmemWEN,     m.busy && m.wr);
            chk("m_busy",     mem_busy,    m.busy);
            chk("m_valid",    valid_me,    !m.busy && m.valid);
            chk("m_regwr",    regWr_me,    !m.busy && m.valid && m.regwr);
            chk("m_addr",     dmemaddr,    m.alu);
            chk("m_store",    dmemstore,   m.st);
            chk("m_dst",      regDst_me,   m.dst);
            chk("m_src",      regSrc_me,   m.src);
            chk("m_alu",      ALUOut_me,   m.alu);
            chk("m_npc",      npc_me,      m.npc);
            chk("m_lui",      lui_me,      m.lui);
            chk("m_load",     dmemload_me, m.ld);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ren"},   dmemREN,     32'd0);
        chk({tag, "_wen"},   dmemWEN,     32'd0);
        chk({tag, "_busy"},  mem_busy,    32'd0);
        chk({tag, "_valid"}, valid_me,    32'd0);
        chk({tag, "_regwr"}, regWr_me,    32'd0);
        chk({tag, "_addr"},  dmemaddr,    32'd0);
        chk({tag, "_alu"},   ALUOut_me,   32'd0);
        chk({tag, "_load"},  dmemload_me, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        int          busy_run;
        n_checks = 0; n_fail = 0; cmp_en = 1'b0; busy_run = 0;
        flush = 1'b0; ex_valid = 1'b0; ex_regWr = 1'b0; ex_memRd = 1'b0; ex_memWr = 1'b0;
        ex_regDst = 5'd0; ex_regSrc = 2'd0; ex_ALUOut = 32'd0; ex_npc = 32'd0;
        ex_lui = 32'd0; ex_store = 32'd0; dhit = 1'b0; dmemload = 32'd0;
`ifdef MEM_STAGE_LLSC_EN
        ex_ll = 1'b0; ex_sc = 1'b0; link_clr = 1'b0;
`endif
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #2 chk_all_zero("rst");
        cyc(); nRST = 1'b1; cmp_en = 1'b1;

        // ALU op
        ex_valid = 1'b1; ex_regWr = 1'b1; ex_regDst = 5'd5; ex_regSrc = 2'b00;
        ex_ALUOut = 32'h1234; ex_npc = 32'h0000_0104; ex_lui = 32'h0012_0000;
        cyc(); ex_valid = 1'b0;
        @(negedge CLK);
        chk("alu_regwr", regWr_me, 32'd1);
        chk("alu_dst",   regDst_me, 32'd5);
        chk("alu_out",   ALUOut_me, 32'h1234);
        chk("alu_valid", valid_me, 32'd1);
        chk("alu_busy",  mem_busy, 32'd0);

        // Load, dhit on the 3rd cycle after entry; EX changes must be ignored
        cyc(); ex_valid = 1'b1; ex_regWr = 1'b1; ex_memRd = 1'b1; ex_regSrc = 2'b11;
        ex_regDst = 5'd7; ex_ALUOut = 32'h40;
        cyc(); ex_ALUOut = 32'h999; ex_regDst = 5'd9; ex_memRd = 1'b0;
        @(negedge CLK);
        chk("ld_ren",   dmemREN,  32'd1);
        chk("ld_addr",  dmemaddr, 32'h40);
        chk("ld_busy0", mem_busy, 32'd1);
        chk("ld_valid", valid_me, 32'd0);
        chk("ld_rw0",   regWr_me, 32'd0);
        cyc(); @(negedge CLK); chk("ld_busy1", mem_busy, 32'd1);
        cyc(); @(negedge CLK); chk("ld_busy2", mem_busy, 32'd1);
        cyc(); dhit = 1'b1; dmemload = 32'hDEADBEEF;
        @(negedge CLK); chk("ld_busy3", mem_busy, 32'd1);
        cyc(); dhit = 1'b0; ex_valid = 1'b0; ex_regWr = 1'b0;
        @(negedge CLK);
        chk("ld_done_busy", mem_busy,    32'd0);
        chk("ld_done_ren",  dmemREN,     32'd0);
        chk("ld_data",      dmemload_me, 32'hDEADBEEF);
        chk("ld_regwr",     regWr_me,    32'd1);
        chk("ld_alu_kept",  ALUOut_me,   32'h40);
        chk("ld_dst_kept",  regDst_me,   32'd7);

        // Store with immediate dhit (dhit while idle is ignored)
        cyc(); ex_valid = 1'b1; ex_memWr = 1'b1; ex_regWr = 1'b0; ex_regSrc = 2'b00;
        ex_ALUOut = 32'h80; ex_store = 32'hA5; dhit = 1'b1;
        cyc(); ex_valid = 1'b0; ex_memWr = 1'b0;
        @(negedge CLK);
        chk("st_wen",   dmemWEN,   32'd1);
        chk("st_ren",   dmemREN,   32'd0);
        chk("st_data",  dmemstore, 32'hA5);
        chk("st_addr",  dmemaddr,  32'h80);
        cyc(); dhit = 1'b0;
        @(negedge CLK);
        chk("st_wen_drop", dmemWEN,     32'd0);
        chk("st_busy",     mem_busy,    32'd0);
        chk("st_regwr",    regWr_me,    32'd0);
        chk("st_ld_hold",  dmemload_me, 32'hDEADBEEF);

        // Flush at capture
        cyc(); ex_valid = 1'b1; ex_memRd = 1'b1; ex_regWr = 1'b1; ex_ALUOut = 32'h44; flush = 1'b1;
        cyc(); flush = 1'b0; ex_valid = 1'b0; ex_memRd = 1'b0; ex_regWr = 1'b0;
        @(negedge CLK);
        chk("fl_ren",   dmemREN,  32'd0);
        chk("fl_busy",  mem_busy, 32'd0);
        chk("fl_valid", valid_me, 32'd0);
        chk("fl_regwr", regWr_me, 32'd0);

        // Reset in the middle of an access
        cyc(); ex_valid = 1'b1; ex_memRd = 1'b1; ex_ALUOut = 32'h60;
        cyc(); ex_valid = 1'b0; ex_memRd = 1'b0;
        @(negedge CLK); chk("mr_ren_before", dmemREN, 32'd1);
        #1 nRST = 1'b0;
        #1 chk_all_zero("mr");
        cyc(); nRST = 1'b1;
        cyc(); @(negedge CLK);
        chk("mr_idle_busy", mem_busy, 32'd0);
        chk("mr_idle_ren",  dmemREN,  32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            r = $urandom;
            ex_valid  = (r[3:0] < 4'd13);
            flush     = (r[7:4] == 4'd0);
            ex_memRd  = (r[9:8] == 2'd0);
            ex_memWr  = (r[12:10] == 3'd0);
            ex_regWr  = r[13];
            ex_regSrc = r[15:14];
            ex_regDst = r[20:16];
            dhit      = (r[23:22] == 2'd0) || (r[24] && r[25]);
            ex_ALUOut = $urandom;
            ex_npc    = $urandom;
            ex_lui    = $urandom;
            ex_store  = $urandom;
            dmemload  = $urandom;
            if (mem_busy) busy_run++;
            else          busy_run = 0;
            if (busy_run > 200) begin
                chk("busy_bound", busy_run, 32'd0);
                break;
            end
        end

`ifdef MEM_STAGE_LLSC_EN
        // LL/SC: drain, then run outside the plain-load/store model
        cyc(); ex_valid = 1'b0; dhit = 1'b1; flush = 1'b0;
        cyc(); cyc(); dhit = 1'b0; cmp_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc(); ex_valid = 1'b1; ex_ll = 1'b1; ex_memRd = 1'b1; ex_memWr = 1'b0;
            ex_regWr = 1'b1; ex_ALUOut = 32'h100;
            cyc(); ex_valid = 1'b0; ex_ll = 1'b0; ex_memRd = 1'b0; dhit = 1'b1;
            cyc(); dhit = 1'b0; link_clr = (k == 1);
            cyc(); link_clr = 1'b0;
            ex_valid = 1'b1; ex_sc = 1'b1; ex_memWr = 1'b1; ex_ALUOut = 32'h100; ex_store = 32'h55;
            cyc(); ex_valid = 1'b0; ex_sc = 1'b0; ex_memWr = 1'b0;
            @(negedge CLK);
            if (k == 0) begin
                chk("sc_wen", dmemWEN, 32'd1);
                cyc(); dhit = 1'b1;
                cyc(); dhit = 1'b0;
                @(negedge CLK);
                chk("sc_ok", dmemload_me, 32'd1);
            end else begin
                chk("sc_nowen", dmemWEN,     32'd0);
                chk("sc_fail",  dmemload_me, 32'd0);
                chk("sc_valid", valid_me,    32'd1);
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
